// File: rtl/us_pkg.sv
// Shared types and constants for the ultrasonic distance filter.
package us_pkg;
    typedef enum logic [1:0] {IDLE, DIV, ACCUM, OUT} state_t;
    localparam int US_CLK_HZ = 50_000_000;
    localparam int DIST_W    = 16;
endpackage

// File: rtl/us_div_seq.sv
// 32/32 unsigned restoring divider, one quotient bit per cycle, fixed 32-cycle latency.
module us_div_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quotient
);
    logic [5:0]  count;
    logic [32:0] rem;
    logic [32:0] shifted;
    logic [32:0] trial;

    // The remainder always stays below the divisor, so 33 bits hold the shifted value
    // and bit 32 of the trial subtraction acts as the borrow.
    assign shifted = {rem[31:0], quotient[31]};
    assign trial   = shifted - {1'b0, divisor};
    assign done    = (count == 6'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            rem      <= '0;
            quotient <= '0;
        end else if (start) begin
            count    <= 6'd32;
            rem      <= '0;
            quotient <= dividend;
        end else if (count != 6'd0) begin
            count <= count - 6'd1;
            if (!trial[32]) begin
                rem      <= trial;
                quotient <= {quotient[30:0], 1'b1};
            end else begin
                rem      <= shifted;
                quotient <= {quotient[30:0], 1'b0};
            end
        end
    end
endmodule

// File: rtl/us_distance_filter.sv
// Echo-width to centimetre conversion, moving-average smoothing and a
// hysteretic proximity flag for the ultrasonic ranger.
module us_distance_filter
    import us_pkg::*;
#(
    parameter int TICKS_PER_CM = 2915,
    parameter int LOG2_DEPTH   = 2,
    parameter int MAX_CM       = 400,
    parameter int NEAR_CM      = 30,
    parameter int HYST_CM      = 10
) (
    input  logic              CLK50MHZ,
    input  logic              reset,
    input  logic [31:0]       echo_ticks,
    input  logic              echo_valid,
    input  logic              echo_timeout,
    output logic              busy,
    output logic [DIST_W-1:0] dist_cm,
    output logic [DIST_W-1:0] avg_cm,
    output logic              avg_valid,
    output logic              near,
    output logic              sample_dropped
);
    localparam int                 DEPTH  = 1 << LOG2_DEPTH;
    localparam int                 SUM_W  = DIST_W + LOG2_DEPTH;
    localparam logic [DIST_W-1:0]  MAX_D  = DIST_W'(MAX_CM);
    localparam logic [DIST_W-1:0]  NEAR_D = DIST_W'(NEAR_CM);
    localparam logic [DIST_W-1:0]  FAR_D  = DIST_W'(NEAR_CM + HYST_CM);
    localparam logic [SUM_W-1:0]   SUM_RST = SUM_W'(DEPTH * MAX_CM);

    state_t                 state;
    logic                   timeout_smp;
    logic [DIST_W-1:0]      cm;
    logic [DIST_W-1:0]      slot [DEPTH];
    logic [SUM_W-1:0]       sum;
    logic [LOG2_DEPTH-1:0]  wp;

    logic                   div_start;
    logic                   div_done;
    logic [31:0]            quot;
    logic [DIST_W-1:0]      cm_acc;
    logic [DIST_W-1:0]      avg_next;

    assign busy      = (state != IDLE);
    assign div_start = (state == IDLE) && echo_valid && !echo_timeout;

    us_div_seq u_div (
        .clk      (CLK50MHZ),
        .reset    (reset),
        .start    (div_start),
        .dividend (echo_ticks),
        .divisor  (32'(TICKS_PER_CM)),
        .done     (div_done),
        .quotient (quot)
    );

    // The quotient only settles on the last DIV edge, so saturation is resolved in ACCUM.
    assign cm_acc   = timeout_smp           ? MAX_D :
                      (quot > 32'(MAX_CM))  ? MAX_D : quot[DIST_W-1:0];
    assign avg_next = DIST_W'(sum >> LOG2_DEPTH);

    always_ff @(posedge CLK50MHZ) begin
        if (reset) begin
            state          <= IDLE;
            timeout_smp    <= 1'b0;
            cm             <= '0;
            sum            <= SUM_RST;
            wp             <= '0;
            dist_cm        <= '0;
            avg_cm         <= MAX_D;
            avg_valid      <= 1'b0;
            near           <= 1'b0;
            sample_dropped <= 1'b0;
            for (int i = 0; i < DEPTH; i++) slot[i] <= MAX_D;
        end else begin
            avg_valid      <= 1'b0;
            sample_dropped <= (state != IDLE) && (echo_valid || echo_timeout);
            case (state)
                IDLE: begin
                    if (echo_timeout) begin
                        timeout_smp <= 1'b1;
                        state       <= ACCUM;
                    end else if (echo_valid) begin
                        timeout_smp <= 1'b0;
                        state       <= DIV;
                    end
                end
                DIV: begin
                    if (div_done) state <= ACCUM;
                end
                ACCUM: begin
                    cm       <= cm_acc;
                    sum      <= sum - SUM_W'(slot[wp]) + SUM_W'(cm_acc);
                    slot[wp] <= cm_acc;
                    wp       <= wp + 1'b1;
                    state    <= OUT;
                end
                OUT: begin
                    dist_cm   <= cm;
                    avg_cm    <= avg_next;
                    avg_valid <= 1'b1;
                    if (avg_next < NEAR_D)
                        near <= 1'b1;
                    else if (avg_next >= FAR_D)
                        near <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
